// File: rtl/k052109_timing_pkg.sv
// Shared constants and helpers for the K052109 phase generator.
// The window function and parameter legality check are used by the top and by sibling blocks.
package k052109_timing_pkg;

    localparam int unsigned DefCntW       = 3;
    localparam int unsigned DefPqStart    = 1;
    localparam int unsigned DefPeLag      = 3;
    localparam int unsigned DefLatchPhase = 3;

    // True when ph sits in the half-period window that opens at start (modulo 2^cnt_w).
    function automatic logic phase_in_window(int unsigned ph, int unsigned start,
                                             int unsigned cnt_w);
        int unsigned period;
        period = 32'd1 << cnt_w;
        return ((ph + period - start) % period) < (period / 2);
    endfunction

    function automatic logic params_legal(int unsigned cnt_w, int unsigned pq_start,
                                          int unsigned pe_lag, int unsigned latch_phase);
        int unsigned period;
        if (cnt_w < 2 || cnt_w > 6) return 1'b0;
        period = 32'd1 << cnt_w;
        return (pq_start < period) && (pe_lag >= 1) && (pe_lag < period)
            && (latch_phase < period);
    endfunction

endpackage

// File: rtl/k052109_rst_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on the 2nd clock edge.
module k052109_rst_sync (
    input  logic clock,
    input  logic reset,
    output logic rst_sync
);

    logic stage1_q;
    logic stage2_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stage1_q <= 1'b0;
            stage2_q <= 1'b0;
        end else begin
            stage1_q <= 1'b1;
            stage2_q <= stage1_q;
        end
    end

    assign rst_sync = stage2_q;

endmodule

// File: rtl/k052109_timing_gen.sv
// K052109 phase strobe generator: M12, PQ, PE, VRAM latch, CPU I/O strobe and VDE
// derived from one phase counter, with run/freeze and synchronous resync.
module k052109_timing_gen
    import k052109_timing_pkg::*;
#(
    parameter int unsigned CNT_W       = DefCntW,
    parameter int unsigned PQ_START    = DefPqStart,
    parameter int unsigned PE_LAG      = DefPeLag,
    parameter int unsigned LATCH_PHASE = DefLatchPhase
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    input  logic resync,
    input  logic crcs,
    input  logic force_io,
    input  logic rmrd,
    output logic m12,
    output logic pq,
    output logic pe,
    output logic vram_latch,
    output logic io_cycle_n,
    output logic vde,
    output logic rst_sync
);

    localparam logic [CNT_W-1:0] LatchPh = CNT_W'(LATCH_PHASE);

    if (!params_legal(CNT_W, PQ_START, PE_LAG, LATCH_PHASE)) begin : g_bad_params
        $error("k052109_timing_gen: parameter out of range");
    end

    logic [CNT_W-1:0]  ph_q, ph_d;
    logic [PE_LAG-1:0] pe_line_q, pe_line_d;
    logic              m12_q, m12_d;
    logic              pq_q, pq_d;
    logic              latch_q, latch_d;
    logic              io_n_q, io_n_d;
    logic              vde_q, vde_d;

    k052109_rst_sync u_rst_sync (
        .clock    (clock),
        .reset    (reset),
        .rst_sync (rst_sync)
    );

    // Everything decodes the pre-edge phase; state only moves on run or resync edges.
    always_comb begin
        ph_d      = ph_q;
        m12_d     = m12_q;
        pq_d      = pq_q;
        pe_line_d = pe_line_q;
        latch_d   = latch_q;
        io_n_d    = io_n_q;
        vde_d     = vde_q;
        if (!rst_sync) begin
            ph_d      = '0;
            m12_d     = 1'b0;
            pq_d      = 1'b0;
            pe_line_d = '0;
            latch_d   = 1'b0;
            io_n_d    = 1'b1;
            vde_d     = 1'b0;
        end else if (run || resync) begin
            ph_d         = resync ? '0 : ph_q + 1'b1;
            m12_d        = ph_q[0];
            pq_d         = phase_in_window(32'(ph_q), PQ_START, CNT_W);
            pe_line_d    = pe_line_q << 1;
            pe_line_d[0] = pq_q;
            latch_d      = (ph_q == LatchPh);
            // Uses the registered pq, so the strobe trails pq by one clock.
            io_n_d       = ~((pq_q & ~crcs) | force_io);
            vde_d        = ph_q[CNT_W-1];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ph_q      <= '0;
            m12_q     <= 1'b0;
            pq_q      <= 1'b0;
            pe_line_q <= '0;
            latch_q   <= 1'b0;
            io_n_q    <= 1'b1;
            vde_q     <= 1'b0;
        end else begin
            ph_q      <= ph_d;
            m12_q     <= m12_d;
            pq_q      <= pq_d;
            pe_line_q <= pe_line_d;
            latch_q   <= latch_d;
            io_n_q    <= io_n_d;
            vde_q     <= vde_d;
        end
    end

    assign m12        = m12_q;
    assign pq         = pq_q;
    assign pe         = pe_line_q[PE_LAG-1];
    assign vram_latch = latch_q;
    assign io_cycle_n = io_n_q;
    assign vde        = vde_q | rmrd;

endmodule

// File: tb/tb_k052109_timing_gen.sv
// Bench for k052109_timing_gen: default and widened instances share random stimulus and are
// compared each clock against a phase-arithmetic reference model.
module tb_k052109_timing_gen;

    localparam int unsigned Cw0 = 3, Lag0 = 3, Lat0 = 3;
    localparam int unsigned Cw1 = 4, Lag1 = 5, Lat1 = 15;
    localparam int unsigned PqStart = 1;

    logic clock, reset, run, resync, crcs, force_io, rmrd;
    logic [1:0] m12, pq, pe, vram_latch, io_cycle_n, vde, rst_sync;

    k052109_timing_gen #(
        .CNT_W(Cw0), .PQ_START(PqStart), .PE_LAG(Lag0), .LATCH_PHASE(Lat0)
    ) u_dut0 (
        .clock(clock), .reset(reset), .run(run), .resync(resync), .crcs(crcs),
        .force_io(force_io), .rmrd(rmrd), .m12(m12[0]), .pq(pq[0]), .pe(pe[0]),
        .vram_latch(vram_latch[0]), .io_cycle_n(io_cycle_n[0]), .vde(vde[0]),
        .rst_sync(rst_sync[0])
    );

    k052109_timing_gen #(
        .CNT_W(Cw1), .PQ_START(PqStart), .PE_LAG(Lag1), .LATCH_PHASE(Lat1)
    ) u_dut1 (
        .clock(clock), .reset(reset), .run(run), .resync(resync), .crcs(crcs),
        .force_io(force_io), .rmrd(rmrd), .m12(m12[1]), .pq(pq[1]), .pe(pe[1]),
        .vram_latch(vram_latch[1]), .io_cycle_n(io_cycle_n[1]), .vde(vde[1]),
        .rst_sync(rst_sync[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase as an integer, outputs from the timing rules.
    int cfg_cw[2], cfg_lag[2], cfg_lat[2];
    int m_ph[2], n_adv[2], sync_cnt;
    bit m_m12[2], m_pq[2], m_pe[2], m_lat[2], m_ion[2], m_vder[2];
    bit pq_log[2][1024];

    function automatic bit in_window(int ph, int cw);
        int p = 1 << cw;
        return ((ph - int'(PqStart) + p) % p) < (p / 2);
    endfunction

    task automatic model_reset();
        sync_cnt = 0;
        for (int k = 0; k < 2; k++) begin
            m_ph[k] = 0; n_adv[k] = 0;
            m_m12[k] = 0; m_pq[k] = 0; m_pe[k] = 0; m_lat[k] = 0; m_ion[k] = 1; m_vder[k] = 0;
        end
    endtask

    task automatic model_edge();
        bit rs_pre;
        rs_pre = (sync_cnt >= 2);
        if (!reset) begin
            model_reset();
            return;
        end
        if (sync_cnt < 2) sync_cnt++;
        if (!rs_pre) return;
        for (int k = 0; k < 2; k++) begin
            if (run || resync) begin
                bit pq_pre;
                int old_ph;
                pq_pre = m_pq[k];
                old_ph = m_ph[k];
                pq_log[k][n_adv[k] % 1024] = pq_pre;
                n_adv[k]++;
                m_pe[k]   = (n_adv[k] >= cfg_lag[k]) ? pq_log[k][(n_adv[k] - cfg_lag[k]) % 1024]
                                                     : 1'b0;
                m_m12[k]  = old_ph[0];
                m_pq[k]   = in_window(old_ph, cfg_cw[k]);
                m_lat[k]  = (old_ph == cfg_lat[k]);
                m_ion[k]  = !((pq_pre && !crcs) || force_io);
                m_vder[k] = (old_ph >= (1 << (cfg_cw[k] - 1)));
                m_ph[k]   = resync ? 0 : (old_ph + 1) % (1 << cfg_cw[k]);
            end
        end
    endtask

    task automatic compare();
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("u%0d.rst_sync", k), 32'(rst_sync[k]), 32'(sync_cnt >= 2));
            check_eq($sformatf("u%0d.m12", k), 32'(m12[k]), 32'(m_m12[k]));
            check_eq($sformatf("u%0d.pq", k), 32'(pq[k]), 32'(m_pq[k]));
            check_eq($sformatf("u%0d.pe", k), 32'(pe[k]), 32'(m_pe[k]));
            check_eq($sformatf("u%0d.vram_latch", k), 32'(vram_latch[k]), 32'(m_lat[k]));
            check_eq($sformatf("u%0d.io_cycle_n", k), 32'(io_cycle_n[k]), 32'(m_ion[k]));
            check_eq($sformatf("u%0d.vde", k), 32'(vde[k]), 32'(m_vder[k] | rmrd));
        end
    endtask

    // Inputs are changed at the falling edge; the model advances on the rising edge.
    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        compare();
        @(negedge clock);
    endtask

    task automatic async_reset_pulse();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        compare();
        @(negedge clock);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_cw  = '{Cw0, Cw1};
        cfg_lag = '{Lag0, Lag1};
        cfg_lat = '{Lat0, Lat1};
        reset = 1'b0; run = 1'b1; resync = 1'b0; crcs = 1'b0; force_io = 1'b0; rmrd = 1'b1;
        model_reset();
        @(negedge clock);
        #1;
        compare();
        step();
        rmrd = 1'b0;
        #1;
        compare();

        // Release: rst_sync rises on the 2nd edge, E0 is the 3rd.
        @(negedge clock);
        reset = 1'b1;
        step();
        check_eq("rst_sync_edge1", 32'(rst_sync[0]), 32'd0);
        step();
        check_eq("rst_sync_edge2", 32'(rst_sync[0]), 32'd1);
        for (int e = 0; e < 32; e++) begin
            step();
            check_eq($sformatf("dir.pq E%0d", e), 32'(pq[0]), 32'(((e + 7) % 8) < 4));
            check_eq($sformatf("dir.latch E%0d", e), 32'(vram_latch[0]), 32'(e % 8 == 3));
            check_eq($sformatf("dir.m12 E%0d", e), 32'(m12[0]), 32'(e % 2));
            check_eq($sformatf("dir.pe E%0d", e), 32'(pe[0]),
                     32'(e >= 3 && ((e + 4) % 8) < 4));
            check_eq($sformatf("dir.io E%0d", e), 32'(io_cycle_n[0]),
                     32'(!(e >= 1 && ((e + 6) % 8) < 4)));
        end

        // Freeze mid-period, resync with run low, then force_io.
        for (int i = 0; i < 3; i++) step();
        run = 1'b0;
        for (int i = 0; i < 5; i++) step();
        run = 1'b1;
        for (int i = 0; i < 3; i++) step();
        run = 1'b0; resync = 1'b1;
        step();
        resync = 1'b0; run = 1'b1; force_io = 1'b1;
        for (int i = 0; i < 4; i++) step();
        force_io = 1'b0;

        // Asynchronous reset mid-period with rmrd high.
        rmrd = 1'b1;
        async_reset_pulse();
        step();
        reset = 1'b1; rmrd = 1'b0;
        for (int i = 0; i < 6; i++) step();

        for (int i = 0; i < 1500; i++) begin
            run      = ($urandom_range(0, 3) != 0);
            resync   = ($urandom_range(0, 9) == 0);
            crcs     = 1'($urandom_range(0, 1));
            force_io = ($urandom_range(0, 7) == 0);
            rmrd     = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 199) == 0) begin
                async_reset_pulse();
                step();
                reset = 1'b1;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/k052109_timing_gen.md
Name: k052109_timing_gen

Overview:
- Parametrised successor to the hand-wired K052109 divider chain (the reset synchroniser, the toggle-flop dividers and the delay taps).
- Generates the chip's phase strobes from one master clock: M12, PQ, PE, the VRAM data latch strobe, the CPU I/O cycle strobe and VDE.
- Period, PQ phase, PE lag and latch phase are parameters.
- New relative to the fixed chain: run/freeze control and synchronous resync, for phase-aligning several chips.
- Sits between the board clock/reset and the tilemap fetch and CPU interface logic.

Parameters:
- CNT_W, 3: phase counter width; period P = 2^CNT_W clocks; legal range 2..6.
- PQ_START, 1: counter value at which the PQ window opens; PQ is high for P/2 consecutive counter values; range 0..P-1.
- PE_LAG, 3: clocks by which PE trails PQ; range 1..P-1.
- LATCH_PHASE, 3: counter value that produces the VRAM latch pulse; range 0..P-1.

Ports:
- clock  in  1  master clock; every flop is rising-edge.
- reset  in  1  reset, asynchronous, active-low.
- run  in  1  1 = advance the phase counter; 0 = freeze all timing state.
- resync  in  1  synchronous reload of the phase counter to 0; has priority over run.
- crcs  in  1  CPU register chip select, active-low.
- force_io  in  1  register 1C00 bit 5; forces the I/O cycle strobe active.
- rmrd  in  1  ROM-read mode; forces VDE high.
- m12  out  1  clock/2 phase.
- pq  out  1  quadrature phase Q.
- pe  out  1  phase E, which is PQ delayed.
- vram_latch  out  1  one-clock VRAM data latch pulse.
- io_cycle_n  out  1  CPU I/O cycle strobe, active-low.
- vde  out  1  video data enable.
- rst_sync  out  1  synchronised reset-release indicator.

Behaviour:
- Reset synchroniser:
  - Two flops with D=1, asynchronously cleared while reset=0.
  - rst_sync goes high on the 2nd rising edge after reset deasserts.
  - reset=0 mid-operation asynchronously clears both flops and all state below in the same instant.
- Reset values (reset=0 or rst_sync=0): ph=0, m12=0, pq=0, pe=0 (including the whole delay line), vram_latch=0, io_cycle_n=1, vde=rmrd.
  - vde is combinationally ORed with rmrd, so it follows rmrd even during reset.
  - While rst_sync=0, all state is held at these values synchronously.
- Definitions: E0 is the first rising edge at which rst_sync=1 is sampled; f(x) = ((x - PQ_START) mod P) < P/2.
- Phase counter ph (CNT_W bits), evaluated each edge with rst_sync=1:
  - resync=1: ph <= 0.
  - else run=1: ph <= ph+1, wrapping from P-1 to 0.
  - else: hold.
- Every registered output below samples the pre-edge ph and updates only on edges where run=1 or resync=1. With run=0 and resync=0, every output holds its value.
  - m12 <= ph[0].
  - pq <= f(ph).
  - pe: shift register of depth PE_LAG fed by pq; pe is the last stage.
  - vram_latch <= (ph == LATCH_PHASE); exactly one clock wide per period.
  - io_cycle_n <= ~((pq & ~crcs) | force_io). Uses the current registered pq, so the strobe trails pq by 1 clock.
  - vde = vde_r | rmrd, with vde_r <= ph[CNT_W-1].
- Simultaneous events:
  - resync together with run: resync wins.
  - resync at ph=0: no visible glitch; the sequence restarts at 0.
  - resync truncates the current period. The pe delay line is not cleared; it keeps shifting pq.
- Latency: every registered output lags its ph decode by 1 clock; pe lags by 1+PE_LAG clocks.
- Width: ph wraps modulo 2^CNT_W. All window comparisons are done in CNT_W bits, modulo P.

Decomposition:
- Package k052109_timing_pkg holds:
  - default parameter constants;
  - the window function f (phase_in_window);
  - parameter-range assertions.
- One natural sub-module: k052109_rst_sync (2-flop asynchronous-assert, synchronous-release reset synchroniser), reused by other blocks.

Test Plan:
- Reset release: reset 0→1 with run=1 → rst_sync=1 after 2 edges; ph=1 after E0; all outputs equal their reset values until then.
- Default parameters, run=1, 32 clocks:
  - pq high after E1..E4, low after E5..E8, repeating with period 8;
  - pe equals pq delayed 3 clocks;
  - m12 toggles every edge;
  - vram_latch high only after E3, E11, E19, E27.
- I/O strobe: crcs=0, force_io=0 → io_cycle_n low exactly 1 clock after each pq high interval begins, 4 clocks wide. force_io=1 → io_cycle_n=0 continuously from the next edge.
- Freeze: run=0 for 5 clocks mid-period → ph, pq, pe, m12, vram_latch and vde all unchanged; sequence resumes seamlessly when run=1.
- Resync: assert resync at ph=5 for 1 clock → ph=0 next edge; then the pq/latch sequence matches the post-E0 pattern. Also assert resync with run=0 → ph=0.
- Async reset mid-run, plus rmrd=1 at any time → rmrd=1 forces vde=1, including while reset is asserted. Reset asserted mid-period → all outputs return to reset values immediately, without waiting for a clock edge. Parameter sweep with CNT_W=4, PE_LAG=5, LATCH_PHASE=15 → pq 8 high / 8 low; pe lag 5; latch one pulse per 16 clocks.
